// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-4 Booth signed multiplier (WIDTH x WIDTH -> low WIDTH bits + overflow).
// Ports: clock/reset_n (sync, active-low); ctrl_MULT start pulse; data_operandA/B signed operands;
//        data_result low word, data_exception signed overflow, data_resultRDY 1-cycle strobe, data_busy.
// Latency: RDY 17 edges after the start edge for WIDTH=32. A new ctrl_MULT aborts any in-flight op.
// Optional: define MULT_HI_EN to add data_result_hi (high word of the full signed product).

// 8-bit carry-lookahead adder slice. Each carry is formed directly from the slice inputs,
// not rippled from the neighbouring bit.
module booth_cla8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       c_o
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       acc;
  logic       prop;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]c_i
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    prop = 1'b1;
    c[0] = c_i;
    for (int i = 1; i <= 8; i++) begin
      acc  = 1'b0;
      prop = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i] = acc | (prop & c_i);
    end
  end

  assign s_o = p ^ c[7:0];
  assign c_o = c[8];
endmodule

module booth_mult_seq #(
  parameter int WIDTH = 32,  // even, >= 8
  parameter int CNT_W = 5    // 2**CNT_W >= WIDTH/2 + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
`ifdef MULT_HI_EN
  ,
  output logic [WIDTH-1:0] data_result_hi
`endif
);

  localparam int AW  = WIDTH + 2;       // partial-product add path width
  localparam int PW  = 2 * WIDTH + 1;   // {hi, lo, q_-1}
  localparam int NSL = (AW + 7) / 8;    // CLA slices covering the add path
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
`ifdef MULT_HI_EN
  logic [WIDTH-1:0] hi_q, hi_d;
`endif

  // ---------------- Booth digit select ----------------
  logic [AW-1:0] m_x1, m_x2, sel_v, op_b, hi_ext, sum;
  logic          sub;

  assign m_x1   = {{2{m_q[WIDTH-1]}}, m_q};
  assign m_x2   = {m_q[WIDTH-1], m_q, 1'b0};
  assign hi_ext = {{2{p_q[PW-1]}}, p_q[PW-1:WIDTH+1]};

  always_comb begin
    sel_v = '0;
    sub   = 1'b0;
    case (p_q[2:0])
      3'b001, 3'b010: sel_v = m_x1;
      3'b011:         sel_v = m_x2;
      3'b100:         begin sel_v = m_x2; sub = 1'b1; end
      3'b101, 3'b110: begin sel_v = m_x1; sub = 1'b1; end
      default:        sel_v = '0;
    endcase
  end

  // Subtract as ~operand + 1; the +1 enters as carry-in of the lowest slice.
  assign op_b = sub ? ~sel_v : sel_v;

  // ---------------- chained CLA slices ----------------
  logic [NSL*8-1:0] add_a, add_b, add_s;
  logic [NSL:0]     add_c;
  logic             unused_add;

  always_comb begin
    add_a         = '0;
    add_b         = '0;
    add_a[AW-1:0] = hi_ext;
    add_b[AW-1:0] = op_b;
  end

  assign add_c[0] = sub;

  for (genvar s = 0; s < NSL; s++) begin : g_cla
    booth_cla8 u_cla (
      .a_i (add_a[8*s +: 8]),
      .b_i (add_b[8*s +: 8]),
      .c_i (add_c[s]),
      .s_o (add_s[8*s +: 8]),
      .c_o (add_c[s+1])
    );
  end

  assign sum        = add_s[AW-1:0];
  // Padding bits above the add path and the final carry are don't-care.
  assign unused_add = ^{add_s, add_c[NSL]};

  // Shift right by 2: the AW-bit sum already carries two guard sign bits, so
  // dropping the two low bits of {sum, lo, q_-1} is the arithmetic shift.
  logic [PW-1:0] p_shift;
  assign p_shift = {sum, p_q[WIDTH:2]};

  // Overflow: hi word and lo sign bit must all agree.
  logic ovf;
  assign ovf = (|p_q[PW-1:WIDTH]) && !(&p_q[PW-1:WIDTH]);

  // ---------------- FSM + datapath next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
`ifdef MULT_HI_EN
    hi_d    = hi_q;
`endif
    if (ctrl_MULT) begin
      // Start, or abort-and-restart from any state; an aborted op never strobes RDY.
      m_d     = data_operandA;
      p_d     = {{WIDTH{1'b0}}, data_operandB, 1'b0};
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          p_d   = p_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
        DONE: begin
          res_d   = p_q[WIDTH:1];
          exc_d   = ovf;
          rdy_d   = 1'b1;
`ifdef MULT_HI_EN
          hi_d    = p_q[PW-1:WIDTH+1];
`endif
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
      p_q   <= '0;
      m_q   <= '0;
      res_q <= '0;
      exc_q <= 1'b0;
      rdy_q <= 1'b0;
`ifdef MULT_HI_EN
      hi_q  <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
      m_q   <= m_d;
      res_q <= res_d;
      exc_q <= exc_d;
      rdy_q <= rdy_d;
`ifdef MULT_HI_EN
      hi_q  <= hi_d;
`endif
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign data_busy      = (state_q == RUN) || (state_q == DONE);
`ifdef MULT_HI_EN
  assign data_result_hi = hi_q;
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         ctrl_MULT;
  logic [W-1:0] data_operandA, data_operandB, data_result;
  logic         data_exception, data_resultRDY, data_busy;
`ifdef MULT_HI_EN
  logic [W-1:0] data_result_hi;
`endif

  booth_mult_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
`ifdef MULT_HI_EN
    ,
    .data_result_hi (data_result_hi)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         exc;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full signed 2W-bit product, then split/overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int due);
    logic signed [2*W-1:0] sa, sbb, full;
    exp_t e;
    sa    = {{W{a[W-1]}}, a};
    sbb   = {{W{b[W-1]}}, b};
    full  = sa * sbb;
    e.lo  = full[W-1:0];
    e.hi  = full[2*W-1:W];
    e.exc = (full[2*W-1:W] != {W{full[W-1]}});
    e.due = due;
    return e;
  endfunction

  // Called at a negedge; the start edge is the next posedge, RDY is expected 17 edges later.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    sb.push_back(model(a, b, cyc + 18));
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || data_busy) && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("drain_in_time", 64'(n < 60), 64'd1);
  endtask

  // Scoreboard: every RDY strobe must match the oldest outstanding operation.
  always @(negedge clock) begin
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        check("rdy_unexpected", 64'(data_resultRDY), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", 64'(data_result), 64'(mon_e.lo));
        check("exception", 64'(data_exception), 64'(mon_e.exc));
        check("rdy_cycle", 64'(cyc), 64'(mon_e.due));
`ifdef MULT_HI_EN
        check("result_hi", 64'(data_result_hi), 64'(mon_e.hi));
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t ref_e;
    int   busy_cnt;
    int   n;
    int   due1;

    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("rst_result", 64'(data_result), 64'd0);
    check("rst_exception", 64'(data_exception), 64'd0);
    check("rst_rdy", 64'(data_resultRDY), 64'd0);
    check("rst_busy", 64'(data_busy), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 7 * -3 with busy-width count
    start(32'd7, 32'hFFFF_FFFD);
    busy_cnt = 0;
    repeat (25) begin
      if (data_busy) busy_cnt++;
      @(negedge clock);
    end
    check("busy_cycles", 64'(busy_cnt), 64'd17);
    ref_e = model(32'd7, 32'hFFFF_FFFD, 0);
    check("hold_result", 64'(data_result), 64'(ref_e.lo));
    wait_idle();

    // Overflow cases
    start(32'h7FFF_FFFF, 32'd2);
    wait_idle();
    start(32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();

    // Reset mid-operation at iteration 5
    start(32'd3, 32'd4);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    sb.delete();
    check("midrst_result", 64'(data_result), 64'd0);
    check("midrst_exception", 64'(data_exception), 64'd0);
    check("midrst_rdy", 64'(data_resultRDY), 64'd0);
    check("midrst_busy", 64'(data_busy), 64'd0);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    check("midrst_idle", 64'(data_busy), 64'd0);
    start(32'd5, 32'd5);
    wait_idle();

    // Abort with a new start at iteration 9
    start(32'd100, 32'd100);
    repeat (9) @(negedge clock);
    void'(sb.pop_back());
    start(32'hFFFF_FFFA, 32'd6);
    wait_idle();

    // Back-to-back: restart on the RDY cycle
    start(32'd9, 32'hFFFF_FFF5);
    due1 = cyc + 17;
    n = 0;
    while (cyc != due1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("b2b_rdy_seen", 64'(data_resultRDY), 64'd1);
    start(32'd0, 32'h1234_5678);
    wait_idle();

`ifdef MULT_HI_EN
    start(32'h0001_0000, 32'h0001_0000);
    wait_idle();
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
`endif

    // A few random signed pairs
    for (int i = 0; i < 4; i++) begin
      start($urandom, $urandom);
      wait_idle();
    end

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
